cpu_mem_harness: RTL and testbench

- Parametrised, synthesizable Harvard memory model for the 5-stage CPU. It replaces the constant i_datain/d_datain stimulus with real instruction and data memories.
- Each memory has a configurable access latency and a req/valid/busy handshake, so the pipeline's stall and hazard logic can be exercised.
- A loader port preloads programs and data before `start`. It sits between the CPU core and the bench.

---
 rtl/cpu_mem_pkg.sv | 13 +
 rtl/mem_lat_port.sv | 107 ++++++++++
 rtl/cpu_mem_harness.sv | 158 +++++++++++++++
 tb/tb_cpu_mem_harness.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU Harvard memory harness.
package cpu_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } port_state_t;

    localparam int   LAT_W    = 3;
    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

endpackage

// File: rtl/mem_lat_port.sv
// One latency-modelled memory port: accepts a request, counts down LAT cycles,
// then completes with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | no access in flight; a request may be accepted
// WAIT  | access accepted, down-counter running toward completion
module mem_lat_port
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_block,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_idle
);

    if (LAT < 1 || LAT > 7) begin : g_bad_lat
        $error("mem_lat_port: LAT=%0d outside legal range 1..7", LAT);
    end

    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LAT - 1);
    localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);

    port_state_t       r_state;
    logic [LAT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_valid;
    logic              r_busy;

    logic w_accept;
    logic w_done;

    assign w_accept = (r_state == IDLE) && i_req && !i_block;

    // With LAT=1 the access completes on its accept edge, so the live
    // request fields address the memory; otherwise the captured ones do.
    assign w_done  = !reset && (((r_state == WAIT) && (r_cnt == CNT_ONE)) ||
                                (w_accept && (LAT == 1)));
    assign o_addr  = (r_state == IDLE) ? i_addr  : r_addr;
    assign o_we    = (r_state == IDLE) ? i_we    : r_we;
    assign o_wdata = (r_state == IDLE) ? i_wdata : r_wdata;
    assign o_done  = w_done;
    assign o_rdata = r_rdata;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_idle  = (r_state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done && !o_we) begin
                r_rdata <= i_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_addr;
                        r_we    <= i_we;
                        r_wdata <= i_wdata;
                        if (LAT > 1) begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_harness.sv
// Harvard instruction/data memory model with latency ports and a preload loader.
// Optional MEM_STATS_EN adds saturating completion counters i_cnt, d_rd_cnt, d_wr_cnt.
module cpu_mem_harness
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int I_LAT  = 1,
    parameter int D_LAT  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    output logic              i_valid,
    output logic              i_busy,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    output logic [DATA_W-1:0] d_datain,
    output logic              d_valid,
    output logic              d_busy,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ack
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       i_cnt,
    output logic [15:0]       d_rd_cnt,
    output logic [15:0]       d_wr_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_imem [0:DEPTH-1];
    logic [DATA_W-1:0] r_dmem [0:DEPTH-1];
    logic              r_load_ack;

    logic              w_i_block, w_d_block;
    logic              w_i_idle, w_d_idle;
    logic              w_i_done, w_d_done;
    logic [ADDR_W-1:0] w_i_addr, w_d_addr;
    logic              w_i_we, w_d_we;
    logic [DATA_W-1:0] w_i_wdata, w_d_wdata;
    logic [DATA_W-1:0] w_i_rdata, w_d_rdata;
    logic              w_load_commit;

    // A loader write on a port suppresses that port's accept, so loader and
    // port writes to the same memory can never land on the same edge.
    assign w_i_block     = load_en && (load_sel == SEL_IMEM);
    assign w_d_block     = load_en && (load_sel == SEL_DMEM);
    assign w_load_commit = !reset && ((w_i_block && w_i_idle) || (w_d_block && w_d_idle));

    assign w_i_rdata = r_imem[w_i_addr];
    assign w_d_rdata = r_dmem[w_d_addr];
    assign load_ack  = r_load_ack;

    mem_lat_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LAT    (I_LAT)
    ) u_iport (
        .clock   (clock),
        .reset   (reset),
        .i_req   (i_req),
        .i_block (w_i_block),
        .i_we    (1'b0),
        .i_addr  (i_addr),
        .i_wdata ({DATA_W{1'b0}}),
        .i_rdata (w_i_rdata),
        .o_addr  (w_i_addr),
        .o_we    (w_i_we),
        .o_wdata (w_i_wdata),
        .o_done  (w_i_done),
        .o_rdata (i_datain),
        .o_valid (i_valid),
        .o_busy  (i_busy),
        .o_idle  (w_i_idle)
    );

    mem_lat_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LAT    (D_LAT)
    ) u_dport (
        .clock   (clock),
        .reset   (reset),
        .i_req   (d_req),
        .i_block (w_d_block),
        .i_we    (d_we),
        .i_addr  (d_addr),
        .i_wdata (d_dataout),
        .i_rdata (w_d_rdata),
        .o_addr  (w_d_addr),
        .o_we    (w_d_we),
        .o_wdata (w_d_wdata),
        .o_done  (w_d_done),
        .o_rdata (d_datain),
        .o_valid (d_valid),
        .o_busy  (d_busy),
        .o_idle  (w_d_idle)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= w_load_commit;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (w_load_commit && (load_sel == SEL_IMEM)) begin
            r_imem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (w_load_commit && (load_sel == SEL_DMEM)) begin
            r_dmem[load_addr] <= load_data;
        end else if (w_d_done && w_d_we) begin
            r_dmem[w_d_addr] <= w_d_wdata;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] r_i_cnt, r_d_rd_cnt, r_d_wr_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_i_cnt    <= '0;
            r_d_rd_cnt <= '0;
            r_d_wr_cnt <= '0;
        end else begin
            if (w_i_done && (r_i_cnt != 16'hFFFF)) begin
                r_i_cnt <= r_i_cnt + 16'd1;
            end
            if (w_d_done && !w_d_we && (r_d_rd_cnt != 16'hFFFF)) begin
                r_d_rd_cnt <= r_d_rd_cnt + 16'd1;
            end
            if (w_d_done && w_d_we && (r_d_wr_cnt != 16'hFFFF)) begin
                r_d_wr_cnt <= r_d_wr_cnt + 16'd1;
            end
        end
    end

    assign i_cnt    = r_i_cnt;
    assign d_rd_cnt = r_d_rd_cnt;
    assign d_wr_cnt = r_d_wr_cnt;
`endif

endmodule

// File: tb/tb_cpu_mem_harness.sv
// Directed self-checking bench for cpu_mem_harness (I_LAT=1, D_LAT=3).
module tb_cpu_mem_harness;
    import cpu_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [7:0]  i_addr = '0;
    logic [15:0] i_datain;
    logic        i_valid, i_busy;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_dataout = '0;
    logic [15:0] d_datain;
    logic        d_valid, d_busy;
    logic        load_en = 1'b0, load_sel = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        load_ack;
`ifdef MEM_STATS_EN
    logic [15:0] i_cnt, d_rd_cnt, d_wr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cpu_mem_harness #(
        .DATA_W (16),
        .ADDR_W (8),
        .I_LAT  (1),
        .D_LAT  (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_datain  (i_datain),
        .i_valid   (i_valid),
        .i_busy    (i_busy),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_datain  (d_datain),
        .d_valid   (d_valid),
        .d_busy    (d_busy),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_ack  (load_ack)
`ifdef MEM_STATS_EN
        ,
        .i_cnt     (i_cnt),
        .d_rd_cnt  (d_rd_cnt),
        .d_wr_cnt  (d_wr_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic sel, input logic [7:0] addr, input logic [15:0] data);
        int n;
        load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
        n = 0;
        do begin
            step();
            n++;
        end while (!load_ack && n < 16);
        chk("load_ack", load_ack, 1);
        load_en = 1'b0;
    endtask

    task automatic d_op(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata);
        int n;
        d_req = 1'b1; d_we = we; d_addr = addr; d_dataout = wdata;
        step();
        d_req = 1'b0;
        n = 0;
        while (!d_valid && n < 16) begin
            step();
            n++;
        end
        chk("d_op_valid", d_valid, 1);
        rdata = d_datain;
    endtask

    task automatic fetch(input logic [7:0] addr, output logic [15:0] rdata);
        int n;
        i_req = 1'b1; i_addr = addr;
        step();
        i_req = 1'b0;
        n = 0;
        while (!i_valid && n < 16) begin
            step();
            n++;
        end
        chk("fetch_valid", i_valid, 1);
        rdata = i_datain;
    endtask

    logic [15:0] rd;

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_i_valid", i_valid, 0);
        chk("rst_i_busy", i_busy, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_busy", d_busy, 0);
        chk("rst_load_ack", load_ack, 0);
        chk("rst_i_datain", i_datain, 0);
        chk("rst_d_datain", d_datain, 0);

        // Preload imem[0x05]; ack exactly one cycle later.
        load_en = 1'b1; load_sel = SEL_IMEM; load_addr = 8'h05; load_data = 16'h4A21;
        step();
        chk("load_ack_next", load_ack, 1);
        load_en = 1'b0;
        step();
        chk("load_ack_pulse", load_ack, 0);

        // Fetch with I_LAT=1: valid next cycle, never busy.
        i_req = 1'b1; i_addr = 8'h05;
        step();
        chk("fetch_valid_t1", i_valid, 1);
        chk("fetch_data", i_datain, 16'h4A21);
        chk("fetch_busy", i_busy, 0);
        i_req = 1'b0;
        step();
        chk("fetch_valid_pulse", i_valid, 0);
        chk("fetch_data_held", i_datain, 16'h4A21);

        // Write 0x10 then back-to-back read issued in the valid cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hBEEF;
        step();
        d_req = 1'b0;
        chk("wr_busy_t1", d_busy, 1);
        chk("wr_valid_t1", d_valid, 0);
        step();
        chk("wr_busy_t2", d_busy, 1);
        chk("wr_valid_t2", d_valid, 0);
        step();
        chk("wr_valid_t3", d_valid, 1);
        chk("wr_busy_t3", d_busy, 0);
        chk("wr_datain_unchanged", d_datain, 16'h0000);
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        step();
        d_req = 1'b0;
        chk("rd_busy_t4", d_busy, 1);
        step();
        chk("rd_valid_t5", d_valid, 0);
        step();
        chk("rd_valid_t6", d_valid, 1);
        chk("rd_data_beef", d_datain, 16'hBEEF);

        // Request while busy is dropped.
        do_load(SEL_DMEM, 8'h20, 16'h0000);
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_dataout = 16'h5555;
        step();
        d_addr = 8'h20; d_dataout = 16'h1234;
        step();
        d_req = 1'b0;
        step();
        chk("busy_req_first_done", d_valid, 1);
        step();
        chk("busy_req_not_queued", d_valid, 0);
        chk("busy_req_no_busy", d_busy, 0);
        d_op(1'b0, 8'h20, 16'h0, rd);
        chk("busy_req_ignored", rd, 16'h0000);
        d_op(1'b0, 8'h40, 16'h0, rd);
        chk("busy_first_write", rd, 16'h5555);

        // Reset mid-access aborts a pending write.
        do_load(SEL_DMEM, 8'h30, 16'h1111);
        d_op(1'b0, 8'h30, 16'h0, rd);
        chk("pre_rst_read", rd, 16'h1111);
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_dataout = 16'hAAAA;
        step();
        d_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", d_busy, 0);
        chk("abort_valid", d_valid, 0);
        chk("abort_datain_cleared", d_datain, 16'h0000);
        step();
        chk("abort_no_valid_a", d_valid, 0);
        step();
        chk("abort_no_valid_b", d_valid, 0);
        d_op(1'b0, 8'h30, 16'h0, rd);
        chk("abort_old_contents", rd, 16'h1111);

        // Loader hold-off while dmem busy; imem fetch unaffected.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h50; d_dataout = 16'h7777;
        step();
        d_req = 1'b0;
        load_en = 1'b1; load_sel = SEL_DMEM; load_addr = 8'h60; load_data = 16'h9999;
        i_req = 1'b1; i_addr = 8'h05;
        step();
        i_req = 1'b0;
        chk("holdoff_fetch_valid", i_valid, 1);
        chk("holdoff_fetch_data", i_datain, 16'h4A21);
        chk("holdoff_ack_t2", load_ack, 0);
        step();
        chk("holdoff_d_valid", d_valid, 1);
        chk("holdoff_ack_t3", load_ack, 0);
        step();
        chk("holdoff_ack_t4", load_ack, 1);
        load_en = 1'b0;
        d_op(1'b0, 8'h60, 16'h0, rd);
        chk("holdoff_load_data", rd, 16'h9999);
        d_op(1'b0, 8'h50, 16'h0, rd);
        chk("holdoff_write_data", rd, 16'h7777);

        // Loader beats a same-cycle fetch on imem; held request goes next.
        load_en = 1'b1; load_sel = SEL_IMEM; load_addr = 8'h06; load_data = 16'h1357;
        i_req = 1'b1; i_addr = 8'h06;
        step();
        load_en = 1'b0;
        chk("prio_ack", load_ack, 1);
        chk("prio_no_fetch", i_valid, 0);
        step();
        i_req = 1'b0;
        chk("prio_fetch_after", i_valid, 1);
        chk("prio_fetch_data", i_datain, 16'h1357);

        // Address wrap: 8-bit address 0xFF then 0x00 are distinct words.
        do_load(SEL_DMEM, 8'hFF, 16'hF00F);
        do_load(SEL_DMEM, 8'h00, 16'h0FF0);
        d_op(1'b0, 8'hFF, 16'h0, rd);
        chk("wrap_ff", rd, 16'hF00F);

`ifdef MEM_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("stats_rst_i", i_cnt, 0);
        chk("stats_rst_drd", d_rd_cnt, 0);
        chk("stats_rst_dwr", d_wr_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            fetch(8'h05, rd);
        end
        d_op(1'b0, 8'h10, 16'h0, rd);
        d_op(1'b0, 8'h60, 16'h0, rd);
        d_op(1'b1, 8'h70, 16'h2222, rd);
        step();
        chk("stats_i", i_cnt, 3);
        chk("stats_drd", d_rd_cnt, 2);
        chk("stats_dwr", d_wr_cnt, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("stats_clr_i", i_cnt, 0);
        chk("stats_clr_drd", d_rd_cnt, 0);
        chk("stats_clr_dwr", d_wr_cnt, 0);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
